// File: rtl/draw_port_arbiter_pkg.sv
// draw_port_arbiter_pkg: shared drawing types, screen geometry and pixel field widths.
package draw_port_arbiter_pkg;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;
    localparam int CNT_W = 17;
    typedef enum logic [1:0] {IDLE, OWN, RELEASE} arb_state_t;
endpackage

// File: rtl/draw_port_arbiter_rr_picker.sv
// rr_picker: first set req bit at or above ptr, wrapping from the top index back to 0.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     ptr,
    output logic [W-1:0]     winner,
    output logic             valid
);
    logic [W-1:0] idx;
    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        valid = 1'b0;
        winner = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N_REQ);
            if (req[idx]) begin
                valid = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: round-robin owner of the single pixel-write port, with per-owner
// timeout and a one-cycle release gap between owners.
module draw_port_arbiter
    import draw_port_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TIMEOUT = 76800
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       done,
    input  logic [X_W*N_REQ-1:0]   x_in,
    input  logic [Y_W*N_REQ-1:0]   y_in,
    input  logic [C_W*N_REQ-1:0]   color_in,
    input  logic [N_REQ-1:0]       plot_in,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [X_W-1:0]         x_out,
    output logic [Y_W-1:0]         y_out,
    output logic [C_W-1:0]         color_out,
    output logic                   plot_out
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    arb_state_t state;
    logic [PW-1:0] ptr, owner, winner, next_ptr;
    logic [CNT_W-1:0] cnt;
    logic valid, own_done, own_req, tmo;

    rr_picker #(.N_REQ(N_REQ), .W(PW)) u_picker (
        .req(req),
        .ptr(ptr),
        .winner(winner),
        .valid(valid)
    );

    assign next_ptr = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
    assign own_done = done[owner];
    assign own_req = req[owner];
    assign tmo = cnt == CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            cnt <= '0;
            grant <= '0;
            busy <= 1'b0;
            timeout_err <= 1'b0;
            x_out <= '0;
            y_out <= '0;
            color_out <= '0;
            plot_out <= 1'b0;
        end else begin
            grant <= '0;
            busy <= 1'b0;
            timeout_err <= 1'b0;
            plot_out <= 1'b0;
            case (state)
                OWN: begin
                    x_out <= x_in[int'(owner)*X_W +: X_W];
                    y_out <= y_in[int'(owner)*Y_W +: Y_W];
                    color_out <= color_in[int'(owner)*C_W +: C_W];
                    plot_out <= plot_in[owner];
                    cnt <= cnt + 1'b1;
                    // done beats a coincident timeout so a clean finish never flags an error.
                    if (own_done || !own_req || tmo) begin
                        state <= RELEASE;
                        timeout_err <= tmo && !own_done;
                    end else begin
                        grant <= grant;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    if (valid) begin
                        state <= OWN;
                        owner <= winner;
                        ptr <= next_ptr;
                        cnt <= '0;
                        grant <= N_REQ'(1) << winner;
                        busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_draw_port_arbiter.sv
// tb_draw_port_arbiter: scenario tasks with a pixel scoreboard stamped by expected output cycle.
module tb_draw_port_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] req = '0, done = '0, plot_in = '0;
    logic [9*N-1:0] x_in = '0;
    logic [8*N-1:0] y_in = '0;
    logic [3*N-1:0] color_in = '0;
    logic [N-1:0] grant;
    logic busy, timeout_err, plot_out;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic [2:0] color_out;

    typedef struct {int cyc; logic [8:0] x; logic [7:0] y; logic [2:0] c;} px_t;
    px_t q[$];
    int cyc_n = 0;
    int errors = 0;
    int checks = 0;

    draw_port_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .plot_in(plot_in),
        .grant(grant), .busy(busy), .timeout_err(timeout_err),
        .x_out(x_out), .y_out(y_out), .color_out(color_out), .plot_out(plot_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Every plot_out must match the head of the queue and arrive in its stamped cycle.
    always @(posedge clk) begin
        px_t e;
        #2;
        if (plot_out) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: got plot_out=1 x=%0d at cycle %0d, required none", x_out, cyc_n);
            end else begin
                e = q.pop_front();
                if (e.cyc !== cyc_n || e.x !== x_out || e.y !== y_out || e.c !== color_out) begin
                    errors++;
                    $display("FAIL pixel: got cyc=%0d x=%0d y=%0d c=%0d, required cyc=%0d x=%0d y=%0d c=%0d",
                             cyc_n, x_out, y_out, color_out, e.cyc, e.x, e.y, e.c);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc_n) begin
            checks++;
            errors++;
            $display("FAIL pixel_missing: got plot_out=0 at cycle %0d, required x=%0d", cyc_n, q[0].x);
            void'(q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input int k, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        plot_in = '0;
        plot_in[k] = 1'b1;
        x_in[k*9 +: 9] = x;
        y_in[k*8 +: 8] = y;
        color_in[k*3 +: 3] = c;
        q.push_back('{cyc: cyc_n + 1, x: x, y: y, c: c});
    endtask

    task automatic reset_dut;
        reset_n = 1'b0;
        req = '0;
        done = '0;
        plot_in = '0;
        step;
        step;
        reset_n = 1'b1;
    endtask

    task automatic chk_grant(input string name, input logic [N-1:0] g, input logic b);
        checks++;
        if (grant !== g || busy !== b) begin
            errors++;
            $display("FAIL %s: got grant=%b busy=%b, required grant=%b busy=%b", name, grant, busy, g, b);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req = '1;
        plot_in = '1;
        done = '1;
        x_in = '1;
        step;
        step;
        checks++;
        if ({grant, busy, timeout_err, plot_out, x_out, y_out, color_out} !== '0) begin
            errors++;
            $display("FAIL reset: got grant=%b busy=%b to=%b plot=%b x=%0d y=%0d c=%0d, required all 0",
                     grant, busy, timeout_err, plot_out, x_out, y_out, color_out);
        end
        x_in = '0;
        reset_dut;
    endtask

    task automatic test_single;
        reset_dut;
        req = 4'b0001;
        step;
        chk_grant("single_grant", 4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_px(0, 9'(10 + i), 8'(20 + i), 3'(i + 1));
            done[0] = (i == 3);
            step;
        end
        plot_in = '0;
        done = '0;
        req = '0;
        chk_grant("single_release", 4'b0000, 1'b0);
        step;
        chk_grant("single_idle", 4'b0000, 1'b0);
        checks++;
        if (plot_out !== 1'b0 || x_out !== 9'd13 || color_out !== 3'd4) begin
            errors++;
            $display("FAIL single_hold: got plot=%b x=%0d c=%0d, required plot=0 x=13 c=4", plot_out, x_out, color_out);
        end
        step;
    endtask

    task automatic test_contention;
        logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_dut;
        req = '1;
        for (int n = 0; n < 5; n++) begin
            step;
            chk_grant($sformatf("contention_grant%0d", n), seq[n], 1'b1);
            for (int c = 0; c < 3; c++) begin
                drive_px(n % N, 9'(100 + 10*n + c), 8'(n), 3'(c));
                done = (c == 2) ? seq[n] : '0;
                step;
                if (c < 2) chk_grant($sformatf("contention_hold%0d_%0d", n, c), seq[n], 1'b1);
            end
            plot_in = '0;
            done = '0;
            chk_grant($sformatf("contention_gap%0d", n), 4'b0000, 1'b0);
        end
        req = '0;
        step;
        step;
    endtask

    task automatic test_timeout;
        reset_dut;
        req = 4'b0011;
        step;
        chk_grant("timeout_own0", 4'b0001, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step;
            checks++;
            if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early%0d: got grant=%b to=%b, required grant=0001 to=0", i, grant, timeout_err);
            end
        end
        step;
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: got grant=%b to=%b, required grant=0000 to=1", grant, timeout_err);
        end
        step;
        chk_grant("timeout_next", 4'b0010, 1'b1);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got to=%b, required 0", timeout_err);
        end
        req = '0;
        step;
        step;
    endtask

    task automatic test_simultaneous;
        reset_dut;
        req = 4'b0001;
        step;
        for (int i = 0; i < 7; i++) step;
        done = 4'b0001;
        step;
        done = '0;
        req = '0;
        checks++;
        if (timeout_err !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL done_vs_timeout: got to=%b grant=%b, required to=0 grant=0000", timeout_err, grant);
        end
        step;
        reset_dut;
        req = 4'b0001;
        step;
        x_in[0 +: 9] = 9'd5;
        plot_in = 4'b0100;
        x_in[18 +: 9] = 9'd300;
        done = 4'b0100;
        step;
        checks++;
        if (plot_out !== 1'b0 || x_out !== 9'd5 || grant !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL non_owner: got plot=%b x=%0d grant=%b busy=%b, required plot=0 x=5 grant=0001 busy=1",
                     plot_out, x_out, grant, busy);
        end
        plot_in = '0;
        done = '0;
        req = '0;
        step;
        step;
    endtask

    task automatic test_reset_mid;
        reset_dut;
        req = 4'b0001;
        step;
        plot_in = 4'b0001;
        x_in[0 +: 9] = 9'd77;
        y_in[0 +: 8] = 8'd7;
        color_in[0 +: 3] = 3'd7;
        reset_n = 1'b0;
        step;
        checks++;
        if ({grant, busy, timeout_err, plot_out, x_out, y_out, color_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got grant=%b busy=%b plot=%b x=%0d, required all 0", grant, busy, plot_out, x_out);
        end
        reset_n = 1'b1;
        plot_in = '0;
        req = 4'b0100;
        step;
        chk_grant("reset_mid_first", 4'b0100, 1'b1);
        done = 4'b0100;
        req = 4'b1111;
        step;
        done = '0;
        step;
        chk_grant("reset_mid_ptr", 4'b1000, 1'b1);
        req = '0;
        step;
        step;
    endtask

    task automatic test_abandon;
        reset_dut;
        req = 4'b0011;
        step;
        chk_grant("abandon_own", 4'b0001, 1'b1);
        req = 4'b0010;
        step;
        chk_grant("abandon_release", 4'b0000, 1'b0);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL abandon_to: got to=%b, required 0", timeout_err);
        end
        req = 4'b0011;
        step;
        chk_grant("abandon_ptr", 4'b0010, 1'b1);
        req = '0;
        step;
        step;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_timeout;
        test_simultaneous;
        test_reset_mid;
        test_abandon;
        step;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending pixels, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/draw_port_arbiter.md
DRAW_PORT_ARBITER -- requirements
Module: draw_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of drawing requesters sharing the single pixel-write port.
REQ-002 Parameter TIMEOUT, default 76800: max cycles one requester may own the port (320x240 full-screen fill).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  N_REQ  per-requester level request; bit k = requester k wants the port.
REQ-006 done  input  N_REQ  per-requester one-cycle pulse marking end of its drawing sequence.
REQ-007 x_in  input  9*N_REQ  packed x coordinates; requester k occupies bits [9k+8:9k].
REQ-008 y_in  input  8*N_REQ  packed y coordinates; requester k occupies bits [8k+7:8k].
REQ-009 color_in  input  3*N_REQ  packed colours; requester k occupies bits [3k+2:3k].
REQ-010 plot_in  input  N_REQ  per-requester pixel write strobe.
REQ-011 grant  output  N_REQ  one-hot ownership indication; all zero when no owner.
REQ-012 busy  output  1  high while any requester owns the port.
REQ-013 timeout_err  output  1  one-cycle pulse when an ownership is revoked by timeout.
REQ-014 x_out  output  9  registered pixel x to the VGA adapter.
REQ-015 y_out  output  8  registered pixel y.
REQ-016 color_out  output  3  registered pixel colour.
REQ-017 plot_out  output  1  registered pixel write strobe.

Function
REQ-018 The FSM SHALL have states IDLE, OWN and RELEASE.
REQ-019 IDLE: if any req bit is high, the FSM SHALL latch the round-robin winner as owner and enter OWN on the next edge; otherwise it SHALL stay in IDLE.
REQ-020 Round-robin: the winner SHALL be the first set req bit at or above pointer ptr, wrapping from N_REQ-1 to 0; on each grant ptr SHALL become (owner+1) mod N_REQ.
REQ-021 In OWN, grant SHALL equal one-hot(owner), busy SHALL be 1, and the owner's x/y/color/plot SHALL be registered to the outputs with exactly one cycle latency.
REQ-022 Outside OWN, plot_out SHALL be 0; x_out, y_out and color_out SHALL hold their last values.
REQ-023 In OWN, done[owner]=1 SHALL cause a transition to RELEASE on the next edge.
REQ-024 In OWN, req[owner]=0 without done SHALL also cause RELEASE. This covers a requester abandoning its request.
REQ-025 done and plot_in from non-owners SHALL be ignored and SHALL NOT affect state or outputs.
REQ-026 A 17-bit cycle counter SHALL clear on entry to OWN and increment each OWN cycle; at count TIMEOUT-1 without done, the FSM SHALL enter RELEASE and pulse timeout_err for one cycle.
REQ-027 If done[owner] and timeout occur in the same cycle, done SHALL win: RELEASE is entered and timeout_err stays 0.
REQ-028 RELEASE SHALL last exactly one cycle with grant=0, busy=0 and plot_out=0, then go to OWN if any req is high (arbitrating as in IDLE), otherwise to IDLE.
REQ-029 Minimum gap between the last owner pixel and the next owner's first pixel SHALL be two cycles: the RELEASE cycle plus the output register.
REQ-030 A requester that keeps req high after done SHALL be re-granted only after all other pending requesters have been served once.

Reset
REQ-031 On reset_n=0 at a clock edge: state SHALL be IDLE, ptr=0, owner=0 and counter=0.
REQ-032 On reset_n=0 at a clock edge: grant, busy, timeout_err, plot_out, x_out, y_out and color_out SHALL all be 0.
REQ-033 Reset asserted mid-OWN SHALL abort ownership immediately; no pixel write SHALL issue in the cycle after reset.

Structure
REQ-034 The state encoding, X_W=9, Y_W=8 and C_W=3 SHALL reside in the shared drawing package, alongside the other screen-geometry constants.
REQ-035 The round-robin priority picker SHALL be one sub-module, rr_picker (inputs req and ptr; outputs winner index and valid).
REQ-036 The FSM, counter and output register SHALL remain in draw_port_arbiter.

Verification
REQ-037 Single requester: req=0001 then 4 pixels with plot_in=1 and done on the 4th cycle -> grant=0001 one cycle after req; 4 plot_out pulses, each one cycle after its plot_in; then RELEASE and IDLE.
REQ-038 Contention: req=1111 held high, each requester sending done after 3 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with one zero-grant cycle between each.
REQ-039 Timeout with TIMEOUT=8: owner never sends done -> RELEASE after 8 OWN cycles; timeout_err pulses once; next requester is granted.
REQ-040 Simultaneous events: done[owner] on the timeout cycle -> timeout_err stays 0. Non-owner done plus plot_in -> no output change.
REQ-041 Reset mid-OWN: reset_n=0 during a write burst -> all outputs 0 next cycle; after release, req=0100 is granted as first winner with ptr=0.
REQ-042 Abandon: owner drops req with no done -> RELEASE next cycle, no timeout_err, ptr advanced.
